// File: rtl/control_multiciclo_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// Holds the state enum, datapath select codes and the condition-code evaluator.
package control_multiciclo_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_RDATA   = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_AND     = 2'b10;
  localparam logic [1:0] ALU_ORR     = 2'b11;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;
  localparam logic [1:0] OP_NOP      = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Instr[31:12] as seen by the controller; rn is carried only to keep the layout.
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rn;
    logic [3:0] rd;
  } instr_f_t;

  function automatic logic cond_holds(input logic [3:0] cond, input nzcv_t f);
    logic r;
    r = 1'b0;
    case (cond)
      COND_EQ: r = f.z;
      COND_NE: r = ~f.z;
      COND_CS: r = f.c;
      COND_CC: r = ~f.c;
      COND_MI: r = f.n;
      COND_PL: r = ~f.n;
      COND_VS: r = f.v;
      COND_VC: r = ~f.v;
      COND_HI: r = f.c & ~f.z;
      COND_LS: r = ~f.c | f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = ~f.z & (f.n == f.v);
      COND_LE: r = f.z | (f.n != f.v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logica_condicion.sv
// NZCV flag register, condition evaluator and the per-instruction CondEx latch.
// CondEx is captured at the end of DECODE and held, so flag writes never affect the current instruction.
module logica_condicion
  import control_multiciclo_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_upd_i,
  input  logic       cv_upd_i,
  input  logic       latch_i,
  output logic       cond_ex_o
);

  nzcv_t flags_q, flags_d;
  logic  cond_ex_q, cond_ex_d;
  logic  holds;

  assign holds = cond_holds(cond_i, flags_q);

  // Logical ops only refresh N and Z; C and V keep the last arithmetic result.
  always_comb begin
    flags_d = flags_q;
    if (flag_upd_i && cond_ex_q) begin
      flags_d.n = alu_flags_i[3];
      flags_d.z = alu_flags_i[2];
      if (cv_upd_i) begin
        flags_d.c = alu_flags_i[1];
        flags_d.v = alu_flags_i[0];
      end
    end
  end

  always_comb begin
    cond_ex_d = cond_ex_q;
    if (latch_i) begin
      cond_ex_d = holds;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= nzcv_t'(FLAGS_RST);
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_o = cond_ex_q;

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback over a shared ALU
// and unified memory, stalling on MemReady; write enables are forced low while reset is asserted.
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         MemReady,
  output logic         PCWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic         MemWrite,
  output logic         AdrSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ALUControl,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [3:0]   State
);

  instr_f_t ir;
  state_e   state_q, state_d;
  logic       cond_ex;
  logic       no_write;
  logic       rd_is_pc;
  logic       flag_upd;
  logic       cv_upd;
  logic [1:0] alu_op;
  logic       pc_we, ir_we, reg_we, mem_we;
  logic       unused_rn;

  assign ir        = instr_f_t'(Instr);
  assign rd_is_pc  = (ir.rd == 4'hF);
  assign unused_rn = ^ir.rn;

  always_comb begin
    alu_op   = ALU_ADD;
    no_write = 1'b0;
    case (ir.funct[4:1])
      4'b0100: alu_op = ALU_ADD;
      4'b0010: alu_op = ALU_SUB;
      4'b0000: alu_op = ALU_AND;
      4'b1100: alu_op = ALU_ORR;
      4'b1010: begin
        alu_op   = ALU_SUB;
        no_write = 1'b1;
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  assign cv_upd   = ~alu_op[1];
  assign flag_upd = ((state_q == EXECUTER) || (state_q == EXECUTEI)) && ir.funct[0];

  logica_condicion #(
    .FLAGS_RST (FLAGS_RST)
  ) u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (ir.cond),
    .alu_flags_i (ALUFlags),
    .flag_upd_i  (flag_upd),
    .cv_upd_i    (cv_upd),
    .latch_i     (state_q == DECODE),
    .cond_ex_o   (cond_ex)
  );

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_RN;
    ALUSrcB    = SRCB_RM;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (MemReady) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (ir.op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = ir.funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_EXTIMM;
        state_d = ir.funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) begin
          state_d = MEMWB;
        end
      end
      MEMWB: begin
        ResultSrc = RES_RDATA;
        reg_we    = cond_ex;
        pc_we     = cond_ex & rd_is_pc;
        state_d   = FETCH;
      end
      // A squashed store has nothing to wait for, so it leaves immediately.
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = cond_ex;
        if (MemReady || !cond_ex) begin
          state_d = FETCH;
        end
      end
      EXECUTER: begin
        ALUControl = alu_op;
        state_d    = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = SRCB_EXTIMM;
        ALUControl = alu_op;
        state_d    = ALUWB;
      end
      ALUWB: begin
        reg_we  = cond_ex & ~no_write;
        pc_we   = cond_ex & rd_is_pc;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALU;
        pc_we     = cond_ex;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate with reset directly so enables drop in the same cycle reset is asserted.
  assign PCWrite  = pc_we  & reset;
  assign IRWrite  = ir_we  & reset;
  assign RegWrite = reg_we & reset;
  assign MemWrite = mem_we & reset;

  assign ImmSrc = ir.op;
  assign RegSrc = {ir.op == OP_MEM, ir.op == OP_BR};
  assign State  = state_q;

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle main controller for the ARM-subset datapath. It replaces the single-cycle control path: it sequences each instruction through fetch, decode, execute, memory and writeback states over a shared ALU and a unified instruction/data memory. It also holds the NZCV flag register and stalls on memory wait states through a ready handshake. It sits between the instruction register/ALU flags and every datapath mux select and write enable.

## Interface
- `FLAGS_RST`, default 4'b0000: NZCV value loaded on reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `Instr`  in  [31:12]  instruction register fields: cond, op, funct, Rd.
- `ALUFlags`  in  4  live ALU N,Z,C,V ([3]=N … [0]=V).
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`  out  1 each  write enables.
- `AdrSrc`  out  1  0 = PC, 1 = ALU result as memory address.
- `ALUSrcA`  out  2  00 Rn, 01 PC, 10 ALU-out register.
- `ALUSrcB`  out  2  00 Rm, 01 ExtImm, 10 constant 4.
- `ResultSrc`  out  2  00 ALU-out register, 01 read-data register, 10 ALU result.
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- `ImmSrc`, `RegSrc`  out  2 each  immediate format / register-port select.
- `State`  out  4  current state, debug only.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD. Holds while MemReady=0. When MemReady=1, IRWrite=1 and PCWrite=1 for that single cycle, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD.
- DECODE latches CondEx from Instr[31:28] against the flag register.
- DECODE transitions: op=01 → MEMADR; op=00 with funct[5]=0 → EXECUTER; op=00 with funct[5]=1 → EXECUTEI; op=10 → BRANCH; op=11 → FETCH as a no-op.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. funct[0]=1 → MEMREAD, else → MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx, then → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondEx, held until MemReady=1, then → FETCH.
- MEMWRITE with CondEx=0: never asserts MemWrite and leaves after one cycle regardless of MemReady.
- EXECUTER: ALUSrcA=00, ALUSrcB=00. EXECUTEI: ALUSrcA=00, ALUSrcB=01. Both decode ALUControl from funct and go to ALUWB.
- ALU decode on funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 (CMP) SUB with NoWrite. Any other value decodes as ADD.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite, then → FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx, then → FETCH.
- Writeback to Rd=1111 (MEMWB/ALUWB): PCWrite=CondEx as well as RegWrite.
- Flag update happens at the end of EXECUTER/EXECUTEI, only when funct[0]=1 and CondEx=1.
  - N and Z always update on that condition.
  - C and V update only for ADD/SUB.
- Condition codes: standard ARM 0000–1101. 1110 is always true; 1111 is treated as never.
- ImmSrc = op. RegSrc[0] = (op==10). RegSrc[1] = (op==01). Both are pure combinational.
- Every output not listed for a state is 0.

## Timing
- Reset asserted: state=FETCH, flags=FLAGS_RST, CondEx=0. All four write enables are forced to 0 asynchronously, including mid-MEMWRITE. Mux selects show FETCH values.
- First fetch is the first rising edge after reset release with MemReady=1.
- Cycle counts with MemReady=1 throughout: LDR 5, STR 4, data-processing 4, branch 3, op=11 2.
- Each memory stall cycle adds exactly one cycle. No write enable repeats during a stall.
- CondEx is constant from the end of DECODE to FETCH, so a flag update in EXECUTE* never alters the current instruction's gating.
- Flags become visible to the next instruction's DECODE.

## Structure
- `control_multiciclo_pkg`: state enum, ALUSrcA/ALUSrcB/ResultSrc select constants, ALUControl codes, condition-code constants.
- One sub-module, `logica_condicion`, containing:
  - the NZCV register with its write gating;
  - the condition evaluator;
  - the CondEx latch.
- The FSM and the ALU decode stay in the top.

## Test plan
- ADD R1,R2,R3 (Instr=0xE0821), MemReady=1: states FETCH→DECODE→EXECUTER→ALUWB; ALUControl=00; RegWrite=1 only in ALUWB; PCWrite only in FETCH.
- SUBS R0,R0,#1 (0xE2500) with ALUFlags=0100 in EXECUTEI → flags=0100. Then BNE (0x1AFFF) has PCWrite=0 in BRANCH, and BEQ (0x0AFFF) has PCWrite=1.
- LDR R4,[R5,#8] (0xE5954) with MemReady=0 for 3 MEMREAD cycles → state holds, RegWrite stays 0, MEMWB reached on cycle 8.
- STREQ R1,[R2] (0x05821) with Z=0 and MemReady=0 → MemWrite never 1, MEMWRITE lasts 1 cycle, then FETCH.
- CMP R1,R2 (0xE1510): ALUControl=01, RegWrite=0 in ALUWB, flags updated from ALUFlags.
- Drop reset during MEMWRITE with MemWrite=1 → MemWrite=0 within the same cycle. After release: State=FETCH, flags=0000.
